ipsxe_floating_point_rne_apm_arbiter_v1_0: RTL
==============================================

Name: ipsxe_floating_point_rne_apm_arbiter_v1_0

Overview:
Shares one z-rounding APM (round-to-nearest-even add of the guard bit into the upper z field) between two requesters. Typical requesters are the group1 and group2 z paths of the invsqrt datapath. The block performs round-robin arbitration with valid/ready handshakes. It drives the operand into the APM and tracks in-flight operations with a tag pipeline matched to the APM latency. It then routes each registered result back to the requester that issued it.

Parameters:
MAN_WIDTH, 52, mantissa width of the floating-point format
RNE, 2, extra rounding bits kept in the result
RNE1, 49, low bits below the rounding point; bit RNE1-1 is the round bit
APM_LAT, 1, APM internal register stages from operand to P (0..3)
IN_W, MAN_WIDTH+1+RNE+RNE1-17, operand width (derived; 87 at defaults)
OUT_W, MAN_WIDTH+1+RNE-17, result width (derived; 38 at defaults)

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
i_req0_valid  in  1  requester 0 operand valid
i_req0_data  in  IN_W  requester 0 operand
o_req0_ready  out  1  requester 0 operand accepted this cycle
i_req1_valid  in  1  requester 1 operand valid
i_req1_data  in  IN_W  requester 1 operand
o_req1_ready  out  1  requester 1 operand accepted this cycle
o_apm_z_rne1  out  IN_W  registered operand driven to the shared APM
i_apm_p  in  OUT_W  APM P output (operand[IN_W-1:RNE1] + operand[RNE1-1])
o_res0_valid  out  1  result for requester 0 valid (single-cycle pulse)
o_res1_valid  out  1  result for requester 1 valid (single-cycle pulse)
o_res_data  out  OUT_W  registered result, shared by both result valids
o_inflight  out  3  number of accepted operations whose result is not yet delivered
o_busy  out  1  o_inflight != 0

Behaviour:
- Decided: one clock i_clk; i_rst is synchronous and active-high.
- Reset values: all valids 0; o_apm_z_rne1 = 0; o_res_data = 0; o_inflight = 0; round-robin pointer last_grant = 1, so requester 0 wins first.
- Arbitration is combinational from the current valids and last_grant:
  - only one valid: that requester is granted;
  - both valid: the requester != last_grant is granted;
  - o_reqN_ready = grant_N. At most one ready is high per cycle. Ready never asserts without the matching valid.
- No output backpressure. The APM has its clock enables tied high, so the pipe never stalls; consumers must sink result pulses.
- On accept at edge k:
  - o_apm_z_rne1 <= granted data;
  - issue-valid and tag (0/1) enter a shift register of depth APM_LAT+1;
  - last_grant <= granted id.
- With no accept, o_apm_z_rne1 holds its value and a bubble (valid 0) enters the tag pipe.
- i_apm_p is valid APM_LAT cycles after o_apm_z_rne1 updates. It is captured into o_res_data at the edge when the tag pipe output is valid.
- Total latency: accept at edge k gives o_resN_valid high during the cycle after edge k+APM_LAT+1. Throughput is one operation per cycle.
- o_res_data holds its last value when no result is delivered.
- o_inflight: +1 on accept, -1 on delivery. If both happen in the same cycle it is unchanged. Maximum value is APM_LAT+2, so no overflow.
- Back-to-back contention: 0,1,0,1 interleave. Tags must never be reordered; results leave in issue order.
- Reset mid-operation:
  - the tag pipe is cleared and in-flight operations are discarded (no result pulse);
  - o_inflight = 0; ready is low during the reset cycle.
- APM_LAT = 0 is legal; the tag pipe depth becomes 1.

Decomposition:
- Shared package ipsxe_floating_point_rne_pkg holds:
  - the IN_W/OUT_W derivation functions;
  - requester id constants REQ0 = 0, REQ1 = 1;
  - the inflight counter width function clog2(APM_LAT+3).
- One natural sub-module: ipsxe_floating_point_rr_arb2_v1_0. It is a two-way round-robin grant with the last_grant register and has no datapath.
- Tag/valid shift register and result routing stay in the top module.
- The bench uses a behavioural APM model with configurable APM_LAT.

Test Plan:
- Single requester: req0 only, data with upper field 5 and bit RNE1-1 = 1, APM_LAT = 1 -> o_req0_ready = 1 in the same cycle; o_res0_valid pulses 3 edges later with o_res_data = 6; o_res1_valid stays 0.
- Contention: both valid for 4 consecutive cycles from reset -> grants 0,1,0,1; results are tagged 0,1,0,1 in order with values matching each operand; o_inflight peaks at 3.
- Round bit clear: upper field 0x3F_FFFF_FFFF, bit RNE1-1 = 0 -> o_res_data = 0x3F_FFFF_FFFF; upper field all-ones with round bit 1 -> result wraps to 0 (APM width), delivered on the correct tag.
- Bubbles: req1 valid on cycles 0 and 3 only -> exactly two o_res1_valid pulses, at cycles 3 and 6; o_res_data is held between pulses; o_busy returns to 0 after the last pulse.
- Reset mid-flight: accept on req0 and req1 on consecutive cycles, assert i_rst on the next cycle -> no result pulses; o_inflight = 0; req0 wins the first post-reset contention.
- APM_LAT = 0 and APM_LAT = 3 builds: the contention scenario repeats with latency 2 and 5 edges respectively, and order is preserved.

Source files
------------

// File: rtl/ipsxe_floating_point_rne_pkg.sv
// Shared definitions for the RNE APM arbiter slice.
// Holds the operand/result width derivations, the requester id constants
// and the width of the in-flight counter.
package ipsxe_floating_point_rne_pkg;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  // Operand width seen by the APM: mantissa + hidden bit + extra rounding
  // bits + low bits, minus the 17 bits the APM port does not carry.
  function automatic int calc_in_w(input int man_width, input int rne, input int rne1);
    return man_width + 1 + rne + rne1 - 17;
  endfunction

  // Result width: the upper field of the operand, above the rounding point.
  function automatic int calc_out_w(input int man_width, input int rne);
    return man_width + 1 + rne - 17;
  endfunction

  // The counter must hold values up to APM_LAT+2.
  function automatic int calc_cnt_w(input int apm_lat);
    return $clog2(apm_lat + 3);
  endfunction

endpackage

// File: rtl/ipsxe_floating_point_rr_arb2_v1_0.sv
// Two-way round-robin grant.
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   valid0, valid1    request valids
//   grant0, grant1    combinational one-hot (or zero) grants
// When both requesters are valid the one that was not granted last wins.
// Grants are suppressed during reset.
module ipsxe_floating_point_rr_arb2_v1_0
  import ipsxe_floating_point_rne_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic valid0,
  input  logic valid1,
  output logic grant0,
  output logic grant1
);

  logic last_grant;

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst) begin
      if (valid0 && valid1) begin
        grant0 = (last_grant == REQ1);
        grant1 = (last_grant == REQ0);
      end else begin
        grant0 = valid0;
        grant1 = valid1;
      end
    end
  end

  // Reset to REQ1 so that requester 0 wins the first contention.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= REQ1;
    end else if (grant0) begin
      last_grant <= REQ0;
    end else if (grant1) begin
      last_grant <= REQ1;
    end
  end

endmodule

// File: rtl/ipsxe_floating_point_rne_apm_arbiter_v1_0.sv
// Shares one z-rounding APM between two requesters.
// Ports:
//   i_clk, i_rst                   clock, synchronous active-high reset
//   i_reqN_valid/i_reqN_data       requester operands
//   o_reqN_ready                   operand accepted this cycle
//   o_apm_z_rne1                   registered operand to the APM
//   i_apm_p                        APM result, APM_LAT cycles after operand
//   o_res0_valid/o_res1_valid      single-cycle result pulses per requester
//   o_res_data                     registered result shared by both pulses
//   o_inflight, o_busy             outstanding operation count / nonzero
// A tag pipe matched to the APM latency records which requester issued each
// operand, so results are returned in issue order to the right requester.
module ipsxe_floating_point_rne_apm_arbiter_v1_0
  import ipsxe_floating_point_rne_pkg::*;
#(
  parameter int MAN_WIDTH = 52,
  parameter int RNE       = 2,
  parameter int RNE1      = 49,
  parameter int APM_LAT   = 1,
  parameter int IN_W      = calc_in_w(MAN_WIDTH, RNE, RNE1),
  parameter int OUT_W     = calc_out_w(MAN_WIDTH, RNE)
)(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_req0_valid,
  input  logic [IN_W-1:0]  i_req0_data,
  output logic             o_req0_ready,
  input  logic             i_req1_valid,
  input  logic [IN_W-1:0]  i_req1_data,
  output logic             o_req1_ready,
  output logic [IN_W-1:0]  o_apm_z_rne1,
  input  logic [OUT_W-1:0] i_apm_p,
  output logic             o_res0_valid,
  output logic             o_res1_valid,
  output logic [OUT_W-1:0] o_res_data,
  output logic [2:0]       o_inflight,
  output logic             o_busy
);

  localparam int CNT_W = calc_cnt_w(APM_LAT);

  logic             grant0;
  logic             grant1;
  logic             accept;
  logic             delivered;
  logic [APM_LAT:0] vld_p;
  logic [APM_LAT:0] tag_p;
  logic [CNT_W-1:0] inflight;

  ipsxe_floating_point_rr_arb2_v1_0 u_arb (
    .clk    (i_clk),
    .rst    (i_rst),
    .valid0 (i_req0_valid),
    .valid1 (i_req1_valid),
    .grant0 (grant0),
    .grant1 (grant1)
  );

  assign o_req0_ready = grant0;
  assign o_req1_ready = grant1;
  assign accept       = grant0 | grant1;
  assign delivered    = o_res0_valid | o_res1_valid;

  // ---- Stage p0: operand register feeding the APM ----
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_apm_z_rne1 <= '0;
    end else if (grant1) begin
      o_apm_z_rne1 <= i_req1_data;
    end else if (grant0) begin
      o_apm_z_rne1 <= i_req0_data;
    end
  end

  // ---- Tag pipe: one entry per APM stage plus the operand register ----
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vld_p <= '0;
      tag_p <= '0;
    end else begin
      vld_p[0] <= accept;
      tag_p[0] <= grant1 ? REQ1 : REQ0;
      for (int i = 1; i <= APM_LAT; i++) begin
        vld_p[i] <= vld_p[i-1];
        tag_p[i] <= tag_p[i-1];
      end
    end
  end

  // ---- Result stage: capture APM output and route by tag ----
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_res0_valid <= 1'b0;
      o_res1_valid <= 1'b0;
      o_res_data   <= '0;
    end else begin
      o_res0_valid <= vld_p[APM_LAT] && (tag_p[APM_LAT] == REQ0);
      o_res1_valid <= vld_p[APM_LAT] && (tag_p[APM_LAT] == REQ1);
      if (vld_p[APM_LAT]) begin
        o_res_data <= i_apm_p;
      end
    end
  end

  // An operation counts as in flight until its result pulse has been seen.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      inflight <= '0;
    end else if (accept && !delivered) begin
      inflight <= inflight + CNT_W'(1);
    end else if (!accept && delivered) begin
      inflight <= inflight - CNT_W'(1);
    end
  end

  assign o_inflight = 3'(inflight);
  assign o_busy     = (inflight != '0);

endmodule
